// File: rtl/timer_bus_slave.sv
// SoC timer bus slave: single-beat req/gnt register access and a 32-bit down-counter
// with one-shot / auto-reload modes, sticky expiry flag and level interrupt.
module timer_bus_slave #(
  parameter int unsigned P_ADDR_WIDTH = 8,
  parameter int unsigned P_DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  output logic                    gnt,
  input  logic [P_ADDR_WIDTH-1:0] addr,
  input  logic [P_DATA_WIDTH-1:0] wdata,
  input  logic                    write_en,
  output logic [P_DATA_WIDTH-1:0] rdata,
  output logic                    irq
);

  localparam int unsigned L_CTRL_W = 3;
  localparam int unsigned L_EN     = 0;
  localparam int unsigned L_RELOAD = 1;
  localparam int unsigned L_IRQ_EN = 2;

  localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_CTRL   = P_ADDR_WIDTH'(8'h00);
  localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_LOAD   = P_ADDR_WIDTH'(8'h04);
  localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_STATUS = P_ADDR_WIDTH'(8'h08);
  localparam logic [P_ADDR_WIDTH-1:0] L_ADDR_COUNT  = P_ADDR_WIDTH'(8'h0C);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [L_CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [P_DATA_WIDTH-1:0] load_q, load_d;
  logic                    expired_q, expired_d;
  logic [P_DATA_WIDTH-1:0] count_q, count_d;

  logic                    accept;
  logic                    wr_ctrl, wr_load, wr_status;
  logic                    en_rise, expiry;
  logic [P_DATA_WIDTH-1:0] rd_mux;

  // Register read mux; reflects state before this edge's updates
  always_comb begin
    rd_mux = '0;
    case (addr)
      L_ADDR_CTRL:   rd_mux = P_DATA_WIDTH'(ctrl_q);
      L_ADDR_LOAD:   rd_mux = load_q;
      L_ADDR_STATUS: rd_mux = P_DATA_WIDTH'(expired_q);
      L_ADDR_COUNT:  rd_mux = count_q;
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    accept    = (state_q == S_IDLE) && req;
    wr_ctrl   = accept && write_en && (addr == L_ADDR_CTRL);
    wr_load   = accept && write_en && (addr == L_ADDR_LOAD);
    wr_status = accept && write_en && (addr == L_ADDR_STATUS);
    en_rise   = wr_ctrl && wdata[L_EN] && !ctrl_q[L_EN];
    expiry    = !en_rise && ctrl_q[L_EN] && (count_q == '0);
  end

  // Handshake FSM plus counter/register next-state
  always_comb begin
    state_d   = state_q;
    gnt_d     = 1'b0;
    rdata_d   = '0;
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    expired_d = expired_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_GRANT;
          gnt_d   = 1'b1;
          if (!write_en) begin
            rdata_d = rd_mux;
          end
        end
      end
      S_GRANT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_status && wdata[0]) begin
      expired_d = 1'b0;
    end

    if (en_rise) begin
      count_d = load_q;
    end else if (ctrl_q[L_EN]) begin
      if (count_q != '0) begin
        count_d = count_q - P_DATA_WIDTH'(1);
      end else begin
        expired_d = 1'b1;
        if (ctrl_q[L_RELOAD]) begin
          count_d = load_q;
        end else begin
          ctrl_d[L_EN] = 1'b0;
        end
      end
    end

    // A bus write to CTRL overrides the one-shot auto-clear of EN
    if (wr_ctrl) begin
      ctrl_d = wdata[L_CTRL_W-1:0];
    end
    if (wr_load) begin
      load_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      load_q    <= '0;
      expired_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      expired_q <= expired_d;
      count_q   <= count_d;
    end
  end

  assign gnt   = gnt_q;
  assign rdata = rdata_q;
  assign irq   = expired_q & ctrl_q[L_IRQ_EN];

  logic unused_expiry;
  assign unused_expiry = expiry;

endmodule

// File: tb/tb_timer_bus_slave.sv
// Self-checking bench for timer_bus_slave: transaction-level reference model checked
// every cycle, plus directed accesses with hand-computed expectations.
module tb_timer_bus_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        gnt;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        write_en;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  timer_bus_slave #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .addr(addr),
    .wdata(wdata), .write_en(write_en), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers and the expected bus outputs
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count, m_rdata;
  bit          m_exp, m_gnt;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return {29'd0, m_ctrl};
    if (a == 8'h04) return m_load;
    if (a == 8'h08) return {31'd0, m_exp};
    if (a == 8'h0C) return m_count;
    return 32'd0;
  endfunction

  always @(posedge clk) begin : model
    bit starting, expiring, acc, wr;
    if (reset) begin
      m_ctrl = '0; m_load = '0; m_count = '0; m_exp = 1'b0;
      m_gnt = 1'b0; m_rdata = '0;
    end else begin
      acc      = req && !m_gnt;
      wr       = acc && write_en;
      m_rdata  = (acc && !write_en) ? model_read(addr) : 32'd0;
      starting = wr && addr == 8'h00 && wdata[0] && !m_ctrl[0];
      expiring = !starting && m_ctrl[0] && m_count == 0;
      if (wr && addr == 8'h08 && wdata[0] && !expiring) m_exp = 1'b0;
      if (expiring) m_exp = 1'b1;
      if (starting) m_count = m_load;
      else if (expiring) begin
        if (m_ctrl[1]) m_count = m_load;
        else m_ctrl[0] = 1'b0;
      end else if (m_ctrl[0]) m_count = m_count - 1;
      if (wr && addr == 8'h00) m_ctrl = wdata[2:0];
      if (wr && addr == 8'h04) m_load = wdata;
      m_gnt = acc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", {31'd0, gnt}, {31'd0, m_gnt});
      check("rdata", rdata, m_rdata);
      check("irq", {31'd0, irq}, {31'd0, m_exp & m_ctrl[2]});
    end
  end

  task automatic bus(input bit we, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    int lat;
    lat = 0;
    r   = 'x;
    @(negedge clk);
    req = 1'b1; write_en = we; addr = a; wdata = d;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(negedge clk);
      if (gnt) begin
        lat = i;
        r   = rdata;
      end
    end
    req = 1'b0;
    check("gnt_latency", lat, 1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    bus(1'b0, a, 32'd0, r);
    check(name, r, exp);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    logic [5:0] pat;
    reset = 1'b1; req = 1'b0; addr = '0; wdata = '0; write_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    rd_chk(8'h00, 32'h0, "rst_ctrl");
    rd_chk(8'h04, 32'h0, "rst_load");
    rd_chk(8'h08, 32'h0, "rst_status");
    rd_chk(8'h0C, 32'h0, "rst_count");

    // One-shot countdown from 5
    wr(8'h04, 32'd5);
    wr(8'h00, 32'h1);
    rd_chk(8'h0C, 32'd4, "os_count_a");
    rd_chk(8'h0C, 32'd2, "os_count_b");
    rd_chk(8'h0C, 32'd0, "os_count_c");
    rd_chk(8'h08, 32'd1, "os_expired");
    rd_chk(8'h00, 32'd0, "os_ctrl_cleared");
    rd_chk(8'h0C, 32'd0, "os_count_held");

    // Auto-reload with interrupt, period 4
    wr(8'h08, 32'h1);
    wr(8'h04, 32'd3);
    wr(8'h00, 32'h7);
    repeat (3) @(negedge clk);
    check("ar_irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("ar_irq_first", {31'd0, irq}, 32'd1);
    wr(8'h08, 32'h1);
    check("ar_w1c_clears", {31'd0, irq}, 32'd0);
    wr(8'h08, 32'h1);
    check("ar_w1c_collide", {31'd0, irq}, 32'd1);
    wr(8'h00, 32'h0);

    // LOAD=0 with reload expires every cycle, so W1C never sticks
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h3);
    rd_chk(8'h08, 32'd1, "ld0_expired");
    wr(8'h08, 32'h1);
    rd_chk(8'h08, 32'd1, "ld0_set_wins");
    wr(8'h00, 32'h0);

    // Freeze, read-only COUNT and unmapped address
    wr(8'h04, 32'd9);
    wr(8'h00, 32'h1);
    wr(8'h00, 32'h0);
    rd_chk(8'h0C, 32'd7, "frozen_count");
    wr(8'h0C, 32'hDEADBEEF);
    wr(8'h40, 32'hDEADBEEF);
    rd_chk(8'h0C, 32'd7, "count_ro");
    rd_chk(8'h40, 32'd0, "unmapped_rd");
    rd_chk(8'h04, 32'd9, "load_rd");

    // Held req: one transaction every two cycles
    @(negedge clk);
    req = 1'b1; write_en = 1'b0; addr = 8'h04;
    ng = 0; pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = gnt;
      ng += int'(gnt);
    end
    req = 1'b0;
    check("held_gnt_count", ng, 3);
    check("held_gnt_pattern", {26'd0, pat}, 32'h15);
    repeat (2) @(negedge clk);
    check("idle_no_gnt", {31'd0, gnt}, 32'd0);

    // Reset during a CTRL write request aborts it
    @(negedge clk);
    req = 1'b1; write_en = 1'b1; addr = 8'h00; wdata = 32'h7; reset = 1'b1;
    ng = 0;
    repeat (3) begin
      @(negedge clk);
      ng += int'(gnt);
    end
    req = 1'b0; reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ng += int'(gnt);
    end
    check("rst_abort_gnt", ng, 0);
    rd_chk(8'h00, 32'h0, "post_rst_ctrl");
    rd_chk(8'h04, 32'h0, "post_rst_load");
    rd_chk(8'h08, 32'h0, "post_rst_status");
    rd_chk(8'h0C, 32'h0, "post_rst_count");

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
